// File: rtl/align_shift_4in_pkg.sv
// align_shift_4in_pkg: lane geometry and alignment helper shared by the alignment stage
package align_shift_4in_pkg;
    localparam int LANES = 4;
    localparam int SIG_W = 4;
    localparam int EXP_W = 5;
    localparam int LOW_EXPAND = 2;
    localparam int GUARD_LSB = 0;
    localparam int FRAC_LSB = GUARD_LSB + LOW_EXPAND;
    localparam int HIDDEN_BIT = FRAC_LSB + SIG_W;
    localparam int HEAD_LSB = HIDDEN_BIT + 1;
    localparam int W = HEAD_LSB + 3;
    localparam int SHIFT_SAT = SIG_W + 1 + LOW_EXPAND;

    function automatic logic [W-1:0] align_lane(
        input logic             sign,
        input logic             zero,
        input logic [SIG_W-1:0] frac,
        input logic [EXP_W-1:0] diff
    );
        logic [W-1:0] base;
        logic [W-1:0] mag;
        base = '0;
        base[HIDDEN_BIT] = 1'b1;
        base[FRAC_LSB +: SIG_W] = frac;
        mag = (zero || diff >= EXP_W'(SHIFT_SAT)) ? '0 : base >> diff;
        return sign ? -mag : mag;
    endfunction
endpackage

// File: rtl/align_shift_4in_max.sv
// max_exp_4in: masked maximum of four exponents, ignoring lanes flagged as zero
module max_exp_4in
    import align_shift_4in_pkg::*;
(
    input  logic [LANES*EXP_W-1:0] lane_exp,
    input  logic [LANES-1:0]       zero,
    output logic [EXP_W-1:0]       max_exp,
    output logic                   all_zero
);
    logic [EXP_W-1:0] m0, m1, m2, m3, hi01, hi23;
    // Zero lanes are forced to 0 so they never win, then a two-level compare tree
    always_comb begin
        m0 = zero[0] ? '0 : lane_exp[0*EXP_W +: EXP_W];
        m1 = zero[1] ? '0 : lane_exp[1*EXP_W +: EXP_W];
        m2 = zero[2] ? '0 : lane_exp[2*EXP_W +: EXP_W];
        m3 = zero[3] ? '0 : lane_exp[3*EXP_W +: EXP_W];
        hi01 = m0 > m1 ? m0 : m1;
        hi23 = m2 > m3 ? m2 : m3;
        max_exp = hi01 > hi23 ? hi01 : hi23;
        all_zero = &zero;
    end
endmodule

// File: rtl/align_shift_4in.sv
// align_shift_4in: two-stage exponent alignment of four products into two's-complement adder lanes
module align_shift_4in
    import align_shift_4in_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_sign,
    input  logic [LANES*EXP_W-1:0] in_exp,
    input  logic [LANES*SIG_W-1:0] in_sig,
    input  logic [LANES-1:0]       in_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*W-1:0]     sigOffset,
    output logic [EXP_W-1:0]       out_exp,
    output logic                   out_all_zero
);
    logic [EXP_W-1:0]       max_exp;
    logic                   all_zero;
    logic                   s1_load, s2_load, ld1, ld2;
    logic                   v1_q, v1_d, v2_q, v2_d;
    logic [EXP_W-1:0]       exp1_q, exp1_d, exp2_q, exp2_d;
    logic [LANES*EXP_W-1:0] diff1_q, diff1_d;
    logic [LANES-1:0]       sign1_q, sign1_d, zero1_q, zero1_d;
    logic [LANES*SIG_W-1:0] frac1_q, frac1_d;
    logic                   az1_q, az1_d, az2_q, az2_d;
    logic [LANES*W-1:0]     lanes2_q, lanes2_d;

    max_exp_4in u_max (
        .lane_exp (in_exp),
        .zero     (in_zero),
        .max_exp  (max_exp),
        .all_zero (all_zero)
    );

    // Pipeline advance: S2 moves when empty or drained, S1 when empty or S2 moves
    always_comb begin
        s2_load = !v2_q || out_ready;
        s1_load = !v1_q || s2_load;
        in_ready = !v1_q || !v2_q || out_ready;
        ld1 = s1_load && in_valid;
        ld2 = s2_load && v1_q;
        v1_d = s1_load ? in_valid : v1_q;
        v2_d = s2_load ? v1_q : v2_q;
        exp1_d = ld1 ? max_exp : exp1_q;
        sign1_d = ld1 ? in_sign : sign1_q;
        zero1_d = ld1 ? in_zero : zero1_q;
        frac1_d = ld1 ? in_sig : frac1_q;
        az1_d = ld1 ? all_zero : az1_q;
        exp2_d = ld2 ? exp1_q : exp2_q;
        az2_d = ld2 ? az1_q : az2_q;
        for (int i = 0; i < LANES; i++) begin
            diff1_d[i*EXP_W +: EXP_W] = ld1 ? (in_zero[i] ? '0 : max_exp - in_exp[i*EXP_W +: EXP_W])
                                            : diff1_q[i*EXP_W +: EXP_W];
            lanes2_d[i*W +: W] = ld2 ? align_lane(sign1_q[i], zero1_q[i], frac1_q[i*SIG_W +: SIG_W],
                                                  diff1_q[i*EXP_W +: EXP_W])
                                     : lanes2_q[i*W +: W];
        end
    end

    // Stage registers; reset drops both valid flags and clears the visible outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            exp1_q <= '0;
            diff1_q <= '0;
            sign1_q <= '0;
            zero1_q <= '0;
            frac1_q <= '0;
            az1_q <= 1'b0;
            exp2_q <= '0;
            az2_q <= 1'b0;
            lanes2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            exp1_q <= exp1_d;
            diff1_q <= diff1_d;
            sign1_q <= sign1_d;
            zero1_q <= zero1_d;
            frac1_q <= frac1_d;
            az1_q <= az1_d;
            exp2_q <= exp2_d;
            az2_q <= az2_d;
            lanes2_q <= lanes2_d;
        end
    end

    assign out_valid = v2_q;
    assign sigOffset = lanes2_q;
    assign out_exp = exp2_q;
    assign out_all_zero = az2_q;
endmodule
